mem_ctrl: RTL

- Sequences all external memory traffic for the pipelined RISC-V core over a single byte-wide synchronous RAM port.
- Arbitrates between the instruction-fetch requester (IF stage) and the data requester (MEM stage, driven by the EX stage's load/store, length and signed controls).
- Serialises each 1/2/4-byte access into byte cycles, assembles little-endian words, sign/zero-extends loads and pulses a per-requester done.

---
 rtl/mem_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial sequencer between the IF/MEM requesters and one
// byte-wide synchronous RAM port. Data side has strict priority.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_load,
    input  logic              mem_store,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [2:0]        mem_length,
    input  logic              mem_signed,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_e;

    state_e            state_q, state_d;
    logic              fetch_q, fetch_d;
    logic              sgn_q, sgn_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [2:0]        req_len;
    logic [1:0]        idx;
    logic              last;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       merged;
    logic [31:0]       ext;
    logic [7:0]        wbyte;

    // Unsupported length codes fall back to a full word.
    always_comb begin
        unique case (mem_length)
            3'd1:    req_len = 3'd1;
            3'd2:    req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // cnt_q is the index of the next byte to issue; the byte
    // arriving on ram_din this cycle is the one before it.
    always_comb begin
        idx       = cnt_q[1:0] - 2'd1;
        last      = (cnt_q == len_q);
        next_addr = base_q + ADDR_W'(cnt_q);
        wbyte     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        merged    = asm_q;
        merged[{idx, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        unique case (len_q)
            3'd1: ext = sgn_q ? {{24{merged[7]}}, merged[7:0]}
                              : {24'b0, merged[7:0]};
            3'd2: ext = sgn_q ? {{16{merged[15]}}, merged[15:0]}
                              : {16'b0, merged[15:0]};
            default: ext = merged;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        sgn_d       = sgn_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            IDLE: begin
                ram_addr_d = '0;
                ram_wr_d   = 1'b0;
                ram_dout_d = 8'h00;
                // A requester still sees its done pulse; skip sampling.
                if (!if_done_q && !mem_done_q) begin
                    if (mem_store) begin
                        state_d    = WRITE;
                        fetch_d    = 1'b0;
                        base_d     = mem_addr;
                        len_d      = req_len;
                        wdata_d    = mem_wdata;
                        cnt_d      = 3'd1;
                        ram_addr_d = mem_addr;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else if (mem_load) begin
                        state_d    = READ;
                        fetch_d    = 1'b0;
                        base_d     = mem_addr;
                        len_d      = req_len;
                        sgn_d      = mem_signed;
                        cnt_d      = 3'd1;
                        asm_d      = '0;
                        ram_addr_d = mem_addr;
                    end else if (if_req && !if_cancel) begin
                        state_d    = READ;
                        fetch_d    = 1'b1;
                        base_d     = if_addr;
                        len_d      = 3'd4;
                        sgn_d      = 1'b0;
                        cnt_d      = 3'd1;
                        asm_d      = '0;
                        ram_addr_d = if_addr;
                    end
                end
            end
            READ: begin
                if (fetch_q && if_cancel) begin
                    state_d    = IDLE;
                    ram_addr_d = '0;
                end else begin
                    asm_d = merged;
                    if (last) begin
                        state_d    = IDLE;
                        ram_addr_d = '0;
                        if (fetch_q) begin
                            if_done_d = 1'b1;
                            if_data_d = merged;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = ext;
                        end
                    end else begin
                        ram_addr_d = next_addr;
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
            end
            WRITE: begin
                if (last) begin
                    state_d     = IDLE;
                    ram_addr_d  = '0;
                    ram_wr_d    = 1'b0;
                    ram_dout_d  = 8'h00;
                    mem_done_d  = 1'b1;
                    mem_rdata_d = '0;
                end else begin
                    ram_addr_d = next_addr;
                    ram_dout_d = wbyte;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_q     <= 1'b0;
            sgn_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            sgn_q       <= sgn_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

endmodule
